// File: rtl/strobe_gen.sv
// Multi-channel strobe generator: one shared period counter, N_CH phase-compared valids, continuous or one-shot burst.
// Latency: o_valid/o_sync/o_done are registered, one cycle after the counter holds the matching value.
// Backpressure: none; i_enable low freezes counter and FSM, i_load restarts the block with new configuration.
module strobe_gen #(
    parameter int NB_COUNT = 4,
    parameter int N_CH     = 4,
    parameter int NB_FRAME = 8
) (
    input  logic                       clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_load,
    input  logic [NB_COUNT-1:0]        i_period,
    input  logic [N_CH*NB_COUNT-1:0]   i_phase,
    input  logic                       i_mode,
    input  logic [NB_FRAME-1:0]        i_nframes,
    input  logic                       i_start,
    output logic [N_CH-1:0]            o_valid,
    output logic                       o_sync,
    output logic                       o_done,
    output logic                       o_busy,
    output logic [NB_COUNT-1:0]        o_count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Configuration registers
    logic [NB_COUNT-1:0]      r_period;
    logic [N_CH*NB_COUNT-1:0] r_phase;
    logic                     r_mode;
    logic [NB_FRAME-1:0]      r_nframes;

    // Datapath state
    logic [NB_COUNT-1:0]      r_cnt;
    logic [NB_FRAME-1:0]      r_frame_cnt;
    state_t                   r_state;
    state_t                   w_state_next;
    logic [N_CH-1:0]          r_valid;
    logic                     r_sync;
    logic                     r_done;

    // Combinational helpers
    logic                     w_run;
    logic                     w_active;
    logic                     w_wrap;
    logic                     w_last;
    logic                     w_done_next;
    logic [N_CH-1:0]          w_hit;

    assign w_run    = (r_state == ST_RUN);
    // Counting runs freely in continuous mode, only inside a burst in one-shot mode; a load always pauses it.
    assign w_active = i_enable && !i_load && (!r_mode || w_run);
    assign w_wrap   = (r_cnt == r_period);
    assign w_last   = w_wrap && (r_frame_cnt == r_nframes);

    // Per-channel phase compare against the shared counter (out-of-range phases simply never match)
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_hit[k] = (r_cnt == r_phase[k*NB_COUNT +: NB_COUNT]);
        end
    end

    // Configuration capture on load; reset defaults give one strobe per 2^NB_COUNT cycles on every channel
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_period  <= '1;
            r_phase   <= '1;
            r_mode    <= 1'b0;
            r_nframes <= '0;
        end else if (i_load) begin
            r_period  <= i_period;
            r_phase   <= i_phase;
            r_mode    <= i_mode;
            r_nframes <= i_nframes;
        end
    end

    // Period counter and frame counter; the end of the last frame returns both to zero for the next burst
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt       <= '0;
            r_frame_cnt <= '0;
        end else if (i_load) begin
            r_cnt       <= '0;
            r_frame_cnt <= '0;
        end else if (w_active) begin
            if (w_wrap) begin
                r_cnt <= '0;
                if (w_run) begin
                    r_frame_cnt <= w_last ? '0 : r_frame_cnt + NB_FRAME'(1);
                end
            end else begin
                r_cnt <= r_cnt + NB_COUNT'(1);
            end
        end
    end

    // Burst FSM state register
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Burst FSM next state: load or continuous mode pins it in IDLE, start is only heard in IDLE
    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        if (i_load || !r_mode) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start && i_enable) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_active && w_last) begin
                        w_state_next = ST_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Registered strobes, forced low on every edge where counting is not active
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= '0;
            r_sync  <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_active) begin
            r_valid <= w_hit;
            r_sync  <= w_wrap;
            r_done  <= w_done_next;
        end else begin
            r_valid <= '0;
            r_sync  <= 1'b0;
            r_done  <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_sync  = r_sync;
    assign o_done  = r_done;
    assign o_busy  = w_run;
    assign o_count = r_cnt;

endmodule

// File: tb/tb_strobe_gen.sv
// Bench for strobe_gen: directed stimulus pushes expected strobe events and level checks into queues.
// Latency: expected events are stamped with the clock edge whose registered result they describe.
// Backpressure: none; a negedge monitor pops and compares, and flags any strobe nobody expected.
module tb_strobe_gen;

    localparam int NB_COUNT = 3;
    localparam int N_CH     = 4;
    localparam int NB_FRAME = 8;

    logic                     clock;
    logic                     i_reset;
    logic                     i_enable;
    logic                     i_load;
    logic [NB_COUNT-1:0]      i_period;
    logic [N_CH*NB_COUNT-1:0] i_phase;
    logic                     i_mode;
    logic [NB_FRAME-1:0]      i_nframes;
    logic                     i_start;
    logic [N_CH-1:0]          o_valid;
    logic                     o_sync;
    logic                     o_done;
    logic                     o_busy;
    logic [NB_COUNT-1:0]      o_count;

    strobe_gen #(
        .NB_COUNT (NB_COUNT),
        .N_CH     (N_CH),
        .NB_FRAME (NB_FRAME)
    ) dut (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_enable  (i_enable),
        .i_load    (i_load),
        .i_period  (i_period),
        .i_phase   (i_phase),
        .i_mode    (i_mode),
        .i_nframes (i_nframes),
        .i_start   (i_start),
        .o_valid   (o_valid),
        .o_sync    (o_sync),
        .o_done    (o_done),
        .o_busy    (o_busy),
        .o_count   (o_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edge counter: after posedge n, cyc == n
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         stamp;
        logic [3:0] v;
        logic       s;
        logic       d;
    } exp_t;

    typedef struct {
        int          stamp;
        int          sel;
        logic [31:0] val;
        string       name;
    } lvl_t;

    localparam int SEL_COUNT = 0;
    localparam int SEL_BUSY  = 1;
    localparam int SEL_VALID = 2;
    localparam int SEL_SYNC  = 3;
    localparam int SEL_DONE  = 4;

    exp_t exp_q[$];
    lvl_t lvl_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic finish_req = 1'b0;

    task automatic push_exp(input int stamp, input logic [3:0] v, input logic s, input logic d);
        exp_t e;
        e.stamp = stamp;
        e.v     = v;
        e.s     = s;
        e.d     = d;
        exp_q.push_back(e);
    endtask

    task automatic push_lvl(input int stamp, input int sel, input logic [31:0] val, input string name);
        lvl_t l;
        l.stamp = stamp;
        l.sel   = sel;
        l.val   = val;
        l.name  = name;
        lvl_q.push_back(l);
    endtask

    // One-shot burst with P=3, nframes=1, phases {5,3,1,0}: ch3 never fires
    task automatic push_burst(input int s);
        push_exp(s + 1, 4'b0001, 1'b0, 1'b0);
        push_exp(s + 2, 4'b0010, 1'b0, 1'b0);
        push_exp(s + 4, 4'b0100, 1'b1, 1'b0);
        push_exp(s + 5, 4'b0001, 1'b0, 1'b0);
        push_exp(s + 6, 4'b0010, 1'b0, 1'b0);
        push_exp(s + 8, 4'b0100, 1'b1, 1'b1);
    endtask

    function automatic logic [31:0] lvl_get(input int sel);
        case (sel)
            SEL_COUNT: return 32'(o_count);
            SEL_BUSY:  return 32'(o_busy);
            SEL_VALID: return 32'(o_valid);
            SEL_SYNC:  return 32'(o_sync);
            default:   return 32'(o_done);
        endcase
    endfunction

    // Monitor: compares away from the active edge; sole owner of the pass/fail counters
    always @(negedge clock) begin
        exp_t e;
        lvl_t l;
        if (o_valid != '0 || o_sync || o_done) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe at edge %0d: got v=%b s=%b d=%b, required none",
                         cyc, o_valid, o_sync, o_done);
            end else begin
                e = exp_q.pop_front();
                if (e.stamp != cyc || e.v != o_valid || e.s != o_sync || e.d != o_done) begin
                    n_fail++;
                    $display("FAIL strobe at edge %0d: got v=%b s=%b d=%b, required edge %0d v=%b s=%b d=%b",
                             cyc, o_valid, o_sync, o_done, e.stamp, e.v, e.s, e.d);
                end
            end
        end
        while (lvl_q.size() > 0 && lvl_q[0].stamp <= cyc) begin
            l = lvl_q.pop_front();
            n_tests++;
            if (l.stamp != cyc || lvl_get(l.sel) !== l.val) begin
                n_fail++;
                $display("FAIL %s at edge %0d (due %0d): got %0h, required %0h",
                         l.name, cyc, l.stamp, lvl_get(l.sel), l.val);
            end
        end
        if (finish_req) begin
            n_tests++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL missing_strobes: %0d expected strobes never seen, next due edge %0d",
                         exp_q.size(), exp_q[0].stamp);
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic run_to(input int e);
        while (cyc < e) step();
    endtask

    task automatic do_load(input logic [NB_COUNT-1:0] p, input logic [N_CH*NB_COUNT-1:0] ph,
                           input logic m, input logic [NB_FRAME-1:0] nf, output int l);
        i_period  = p;
        i_phase   = ph;
        i_mode    = m;
        i_nframes = nf;
        i_load    = 1'b1;
        step();
        l = cyc;
        i_load = 1'b0;
    endtask

    initial begin
        int r;
        int ld;
        int s;
        int s2;

        i_reset   = 1'b1;
        i_enable  = 1'b1;
        i_load    = 1'b0;
        i_period  = '0;
        i_phase   = '0;
        i_mode    = 1'b0;
        i_nframes = '0;
        i_start   = 1'b0;

        // Reset state
        push_lvl(2, SEL_COUNT, 0, "rst_count");
        push_lvl(2, SEL_BUSY,  0, "rst_busy");
        push_lvl(2, SEL_VALID, 0, "rst_valid");
        push_lvl(2, SEL_SYNC,  0, "rst_sync");
        push_lvl(2, SEL_DONE,  0, "rst_done");
        step(); step(); step();

        // Defaults: period 7, all phases 7 -> all channels plus sync every 8 cycles, first at cycle 8
        i_reset = 1'b0;
        r = cyc;
        for (int n = 1; n <= 3; n++) push_exp(r + 8*n, 4'hF, 1'b1, 1'b0);
        push_lvl(r + 5, SEL_COUNT, 5, "dflt_count5");
        push_lvl(r + 7, SEL_BUSY,  0, "cont_start_ignored");
        push_lvl(r + 8, SEL_COUNT, 0, "dflt_wrap");
        run_to(r + 6);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        run_to(r + 26);

        // Staggered phases {0,1,2,7}, P=4, continuous; then a 3-cycle enable gap at count 2
        do_load(3'd4, {3'd7, 3'd2, 3'd1, 3'd0}, 1'b0, 8'd0, ld);
        for (int n = 0; n < 3; n++) begin
            push_exp(ld + 1 + 5*n, 4'b0001, 1'b0, 1'b0);
            push_exp(ld + 2 + 5*n, 4'b0010, 1'b0, 1'b0);
            push_exp(ld + 3 + 5*n, 4'b0100, 1'b0, 1'b0);
            push_exp(ld + 5 + 5*n, 4'b0000, 1'b1, 1'b0);
        end
        push_exp(ld + 16, 4'b0001, 1'b0, 1'b0);
        push_exp(ld + 17, 4'b0010, 1'b0, 1'b0);
        push_exp(ld + 21, 4'b0100, 1'b0, 1'b0);
        push_exp(ld + 23, 4'b0000, 1'b1, 1'b0);
        push_exp(ld + 24, 4'b0001, 1'b0, 1'b0);
        push_exp(ld + 25, 4'b0010, 1'b0, 1'b0);
        push_exp(ld + 26, 4'b0100, 1'b0, 1'b0);
        push_exp(ld + 28, 4'b0000, 1'b1, 1'b0);
        push_lvl(ld + 0, SEL_COUNT, 0, "stag_count0");
        push_lvl(ld + 1, SEL_COUNT, 1, "stag_count1");
        push_lvl(ld + 2, SEL_COUNT, 2, "stag_count2");
        push_lvl(ld + 3, SEL_COUNT, 3, "stag_count3");
        push_lvl(ld + 4, SEL_COUNT, 4, "stag_count4");
        push_lvl(ld + 5, SEL_COUNT, 0, "stag_count_wrap");
        push_lvl(ld + 17, SEL_COUNT, 2, "gap_count_pre");
        push_lvl(ld + 18, SEL_COUNT, 2, "gap_count_hold1");
        push_lvl(ld + 18, SEL_VALID, 0, "gap_valid_low");
        push_lvl(ld + 19, SEL_COUNT, 2, "gap_count_hold2");
        push_lvl(ld + 20, SEL_COUNT, 2, "gap_count_hold3");
        run_to(ld + 17);
        i_enable = 1'b0;
        run_to(ld + 20);
        i_enable = 1'b1;
        run_to(ld + 28);

        // One-shot: P=3, nframes=1, phases {5,3,1,0}; back-to-back restart; start ignored mid-burst
        do_load(3'd3, {3'd5, 3'd3, 3'd1, 3'd0}, 1'b1, 8'd1, ld);
        push_lvl(ld, SEL_BUSY, 0, "os_idle_busy");
        push_lvl(ld + 2, SEL_COUNT, 0, "os_idle_count");
        run_to(ld + 2);
        i_start = 1'b1;
        step();
        s = cyc;
        i_start = 1'b0;
        s2 = s + 9;
        push_burst(s);
        push_burst(s2);
        push_lvl(s, SEL_BUSY, 1, "os_busy_rise");
        push_lvl(s + 7, SEL_BUSY, 1, "os_busy_last");
        push_lvl(s + 8, SEL_BUSY, 0, "os_busy_fall");
        push_lvl(s + 8, SEL_COUNT, 0, "os_count_end");
        push_lvl(s2, SEL_BUSY, 1, "os2_busy_rise");
        push_lvl(s2 + 8, SEL_BUSY, 0, "os2_busy_fall");
        push_lvl(s2 + 12, SEL_BUSY, 0, "os2_busy_after");
        push_lvl(s2 + 12, SEL_COUNT, 0, "os2_count_after");
        run_to(s + 8);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        run_to(s2 + 2);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        run_to(s2 + 12);

        // Period 0: ch0 (phase 0) and sync high every cycle; then reload mid-stream
        do_load(3'd0, {3'd7, 3'd7, 3'd1, 3'd0}, 1'b0, 8'd0, ld);
        for (int j = 1; j <= 6; j++) push_exp(ld + j, 4'b0001, 1'b1, 1'b0);
        push_lvl(ld + 3, SEL_COUNT, 0, "p0_count");
        push_lvl(ld + 3, SEL_VALID, 1, "p0_valid");
        run_to(ld + 6);
        do_load(3'd3, {3'd5, 3'd3, 3'd1, 3'd0}, 1'b1, 8'd1, ld);
        push_lvl(ld, SEL_VALID, 0, "reload_valid");
        push_lvl(ld, SEL_SYNC,  0, "reload_sync");
        push_lvl(ld, SEL_BUSY,  0, "reload_busy");

        // Asynchronous reset mid-burst, between edges, while ch1 is strobing
        run_to(ld + 1);
        i_start = 1'b1;
        step();
        s = cyc;
        i_start = 1'b0;
        push_exp(s + 1, 4'b0001, 1'b0, 1'b0);
        push_lvl(s + 1, SEL_BUSY, 1, "ar_busy_pre");
        run_to(s + 2);
        #1;
        i_reset = 1'b1;
        push_lvl(s + 2, SEL_VALID, 0, "ar_valid");
        push_lvl(s + 2, SEL_SYNC,  0, "ar_sync");
        push_lvl(s + 2, SEL_BUSY,  0, "ar_busy");
        push_lvl(s + 2, SEL_COUNT, 0, "ar_count");
        step(); step();
        i_reset = 1'b0;
        r = cyc;
        push_exp(r + 8,  4'hF, 1'b1, 1'b0);
        push_exp(r + 16, 4'hF, 1'b1, 1'b0);
        push_lvl(r + 4, SEL_COUNT, 4, "post_rst_count");
        push_lvl(r + 4, SEL_BUSY,  0, "post_rst_busy");
        run_to(r + 18);
        finish_req = 1'b1;
    end

endmodule
